load_store_unit: RTL and testbench

Sits between the pipeline MEM stage and the byte-addressed 64-bit data memory. Accepts one load/store request at a time and issues the memory's single-port, 8-byte little-endian read/write cycles. Sub-doubleword stores use a read-modify-write sequence, and loads return sign/zero-extended results. Out-of-range accesses are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states, size helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: load extraction with sign/zero extension, and
// merging of store bytes into the low lanes of a fetched doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  always_comb begin
    load_data = word;
    merged    = word;
    case (size)
      SZ_B: begin
        load_data     = {{56{~is_unsigned & word[7]}}, word[7:0]};
        merged[7:0]   = wdata[7:0];
      end
      SZ_H: begin
        load_data     = {{48{~is_unsigned & word[15]}}, word[15:0]};
        merged[15:0]  = wdata[15:0];
      end
      SZ_W: begin
        load_data     = {{32{~is_unsigned & word[31]}}, word[31:0]};
        merged[31:0]  = wdata[31:0];
      end
      default: begin
        load_data     = word;
        merged        = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between MEM stage and a single-port 64-bit byte-addressed memory.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 9192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        resp_misaligned,
  output logic        dm_rw,
  output logic [63:0] dm_addr,
  inout  logic [63:0] dm_data
);

  lsu_state_t  state, next_state;
  logic        st_store;
  logic [1:0]  st_size;
  logic        st_uns;
  logic [63:0] st_addr;
  logic [63:0] st_wdata;
  logic [63:0] merge_buf;
  logic [63:0] rdata_q;
  logic        fault_q;
  logic        mis_q;

  logic [3:0]  req_bytes;
  logic [64:0] end_addr;
  logic        range_fault;
  logic        misaligned;
  logic [63:0] load_data;
  logic [63:0] merged;

  assign req_bytes   = size_bytes(req_size);
  // 65-bit sum so addresses near 2^64 cannot wrap past the bound
  assign end_addr    = {1'b0, req_addr} + {61'd0, req_bytes};
  assign range_fault = end_addr > 65'(MEM_SIZE);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = |(req_addr[2:0] & 3'(req_bytes - 4'd1));
`else
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .size        (st_size),
    .is_unsigned (st_uns),
    .word        (dm_data),
    .wdata       (st_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dm_rw      = 1'b0;
    dm_addr    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (range_fault || misaligned) next_state = RESP;
          else if (!req_store)           next_state = LOAD;
          else if (req_size == SZ_D)     next_state = WRITE;
          else                           next_state = RMW_RD;
        end
      end
      LOAD: begin
        dm_addr    = st_addr;
        next_state = RESP;
      end
      RMW_RD: begin
        dm_addr    = st_addr;
        next_state = WRITE;
      end
      WRITE: begin
        dm_rw      = 1'b1;
        dm_addr    = st_addr;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_store  <= 1'b0;
      st_size   <= SZ_B;
      st_uns    <= 1'b0;
      st_addr   <= '0;
      st_wdata  <= '0;
      merge_buf <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            st_store  <= req_store;
            st_size   <= req_size;
            st_uns    <= req_unsigned;
            st_addr   <= req_addr;
            st_wdata  <= req_wdata;
            merge_buf <= req_wdata;
            rdata_q   <= '0;
            fault_q   <= range_fault;
            mis_q     <= misaligned;
          end
        end
        LOAD:    rdata_q   <= load_data;
        RMW_RD:  merge_buf <= merged;
        default: ;
      endcase
    end
  end

  assign dm_data         = dm_rw ? merge_buf : 'z;
  assign resp_rdata      = rdata_q;
  assign resp_fault      = fault_q;
  assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory model and
// a scoreboard of expected responses.
module tb_load_store_unit;

  localparam int unsigned MEM_SIZE = 9192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        resp_misaligned;
  logic        dm_rw;
  logic [63:0] dm_addr;
  wire  [63:0] dm_data;

  logic [7:0]  mem [MEM_SIZE];
  logic [63:0] mem_word;
  logic        mem_clear = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        fault;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .resp_misaligned (resp_misaligned),
    .dm_rw           (dm_rw),
    .dm_addr         (dm_addr),
    .dm_data         (dm_data)
  );

  assign dm_data = dm_rw ? 'z : mem_word;

  always_comb begin
    mem_word = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (dm_addr + 64'(i) < 64'(MEM_SIZE))
        mem_word[8*i +: 8] = mem[32'(dm_addr) + i];
    end
  end

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int unsigned i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
    end else if (dm_rw) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (dm_addr + 64'(i) < 64'(MEM_SIZE))
          mem[32'(dm_addr) + i] <= dm_data[8*i +: 8];
      end
    end
  end

  // Drive one request, push its expected response, wait for it and check
  // latency, memory write count, response fields and handshake.
  task automatic issue(input string name, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rdata, input logic exp_fault,
                       input logic exp_mis, input int hold);
    exp_t e;
    exp_t got;
    int   lat_exp;
    int   n;
    int   writes;
    logic [63:0] r0;
    logic f0, m0;
    lat_exp = (exp_fault || exp_mis) ? 1 : (!st || sz == 2'd3) ? 2 : 3;
    sb.push_back('{rdata: exp_rdata, fault: exp_fault, mis: exp_mis});
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 1; writes = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      if (dm_rw === 1'b1) writes++;
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s timeout: no resp_valid after %0d cycles", name, n);
      void'(sb.pop_front());
      return;
    end
    if (n != lat_exp) begin
      n_fail++; $display("FAIL %s latency: got T0+%0d expected T0+%0d", name, n, lat_exp);
    end
    n_checks++;
    if (writes != ((st && !exp_fault && !exp_mis) ? 1 : 0)) begin
      n_fail++; $display("FAIL %s writes: got %0d expected %0d", name, writes,
                         (st && !exp_fault && !exp_mis) ? 1 : 0);
    end
    r0 = resp_rdata; f0 = resp_fault; m0 = resp_misaligned;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== r0 ||
          resp_fault !== f0 || resp_misaligned !== m0) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h expected valid=1 ready=0 rdata=%h",
                 name, h, resp_valid, req_ready, resp_rdata, r0);
      end
    end
    e = sb.pop_front();
    got = '{rdata: resp_rdata, fault: resp_fault, mis: resp_misaligned};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s resp: got rdata=%h fault=%b mis=%b expected rdata=%h fault=%b mis=%b",
               name, got.rdata, got.fault, got.mis, e.rdata, e.fault, e.mis);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s handshake: valid=%b ready=%b expected valid=0 ready=1",
                         name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 ||
        resp_fault !== 1'b0 || resp_misaligned !== 1'b0 || dm_rw !== 1'b0 ||
        dm_addr !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: ready=%b valid=%b rdata=%h fault=%b mis=%b rw=%b addr=%h expected 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_fault, resp_misaligned, dm_rw, dm_addr);
    end
    @(negedge clk);
    rst = 1'b0; mem_clear = 1'b0;
  endtask

  task automatic test_store_load_d();
    issue("sd_100", 1, 2'd3, 0, 64'h100, 64'h0C3C3EAAF00FCC33, 64'd0, 0, 0, 0);
    issue("ld_100", 0, 2'd3, 0, 64'h100, 64'd0, 64'h0C3C3EAAF00FCC33, 0, 0, 0);
  endtask

  task automatic test_store_byte();
    issue("sb_101", 1, 2'd0, 0, 64'h101, 64'hDEADBEEFCAFE5580 , 64'd0, 0, 0, 0);
    issue("ld_100b", 0, 2'd3, 0, 64'h100, 64'd0, 64'h0C3C3EAAF00F8033, 0, 0, 0);
    issue("lb_101", 0, 2'd0, 0, 64'h101, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, 0, 0);
    issue("lbu_101", 0, 2'd0, 1, 64'h101, 64'd0, 64'h0000000000000080, 0, 0, 0);
  endtask

  task automatic test_load_ext();
    issue("lh_102", 0, 2'd1, 0, 64'h102, 64'd0, 64'hFFFFFFFFFFFFF00F, 0, 0, 0);
    issue("lhu_102", 0, 2'd1, 1, 64'h102, 64'd0, 64'h000000000000F00F, 0, 0, 0);
    issue("lw_104", 0, 2'd2, 0, 64'h104, 64'd0, 64'h000000000C3C3EAA, 0, 0, 0);
  endtask

  task automatic test_bounds();
    issue("ld_9185", 0, 2'd3, 0, 64'd9185, 64'd0, 64'd0, 1, 0, 0);
    issue("ld_9184", 0, 2'd3, 0, 64'd9184, 64'd0, 64'd0, 0, 0, 0);
    issue("sb_9191", 1, 2'd0, 0, 64'd9191, 64'h5A, 64'd0, 0, 0, 0);
    issue("lbu_9191", 0, 2'd0, 1, 64'd9191, 64'd0, 64'h5A, 0, 0, 0);
    issue("sw_9190", 1, 2'd2, 0, 64'd9190, 64'h11223344, 64'd0, 1, 0, 0);
    issue("lbu_9191b", 0, 2'd0, 1, 64'd9191, 64'd0, 64'h5A, 0, 0, 0);
  endtask

  task automatic test_unaligned();
`ifdef LSU_MISALIGN_CHECK_EN
    issue("lw_102", 0, 2'd2, 1, 64'h102, 64'd0, 64'd0, 0, 1, 0);
`else
    issue("lw_102", 0, 2'd2, 1, 64'h102, 64'd0, 64'h000000003EAAF00F, 0, 0, 0);
`endif
  endtask

  task automatic test_backpressure();
    issue("lw_104_bp", 0, 2'd2, 0, 64'h104, 64'd0, 64'h000000000C3C3EAA, 0, 0, 3);
  endtask

  task automatic test_reset_mid_rmw();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h100; req_wdata = 64'hA5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    n_checks++;
    if (dm_rw !== 1'b0 || dm_addr !== 64'h100) begin
      n_fail++; $display("FAIL rst_rmw rd: rw=%b addr=%h expected rw=0 addr=100", dm_rw, dm_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dm_rw !== 1'b0) begin
      n_fail++; $display("FAIL rst_rmw idle: ready=%b valid=%b rw=%b expected 1 0 0",
                         req_ready, resp_valid, dm_rw);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mem[256] !== 8'h33) begin
      n_fail++; $display("FAIL rst_rmw mem: byte@100=%h expected 33", mem[256]);
    end
    issue("ld_100_after_rst", 0, 2'd3, 0, 64'h100, 64'd0, 64'h0C3C3EAAF00F8033, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_store_load_d();
    test_store_byte();
    test_load_ext();
    test_bounds();
    test_unaligned();
    test_backpressure();
    test_reset_mid_rmw();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
